// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm -- cache miss fill engine.
//
// On a miss it streams one block (WORDS_PER_BLOCK 16-bit words) from main
// memory into the data array, then pulses the tag write. fsm_busy stays high
// for the whole fill so the pipeline can stall.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   miss_detected       lookup missed; sampled only while idle
//   miss_address        byte address of the missing access
//   fsm_busy            fill in progress (stall the pipeline)
//   mem_en              memory read request valid this cycle
//   memory_address      byte address of the current request
//   memory_data_valid   memory_data carries a returned word (in request order)
//   memory_data         returned word
//   write_data_array    write data_word into the data array at word_sel
//   word_sel            word offset within the block for the array write
//   data_word           word to write (pass-through of memory_data)
//   write_tag_array     one-cycle pulse: write tag / set valid for base_address
//   base_address        block-aligned address of the fill in progress
//   fill_count          completed fills, saturating (only with CACHE_FILL_PERF_EN)
//
// Build option: define CACHE_FILL_PERF_EN to add the fill_count output.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    output logic                               fsm_busy,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  memory_address,
    input  logic                               memory_data_valid,
    input  logic [ADDR_W-1:0]                  memory_data,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_sel,
    output logic [ADDR_W-1:0]                  data_word,
    output logic                               write_tag_array,
    output logic [ADDR_W-1:0]                  base_address
`ifdef CACHE_FILL_PERF_EN
    ,
    output logic [15:0]                        fill_count
`endif
);

    localparam int SEL_W = $clog2(WORDS_PER_BLOCK);
    // Byte offset mask of one block (2 bytes per word).
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    // MEM_LATENCY does not affect the logic (returns are counted, not cycles);
    // it is only sanity-checked here.
    if (MEM_LATENCY < 1 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
        $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK a power of 2");
    end

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, next_state;
    // One extra bit so a count of WORDS_PER_BLOCK means "all done".
    logic [SEL_W:0]   req_cnt, rcv_cnt;
    logic [SEL_W-1:0] req_idx;

    // After the last request the address holds on the final word.
    assign req_idx        = req_cnt[SEL_W] ? '1 : req_cnt[SEL_W-1:0];
    assign memory_address = base_address + ADDR_W'({req_idx, 1'b0});

    always_comb begin
        next_state       = state;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected)
                    next_state = FILL;
            end
            FILL: begin
                fsm_busy = 1'b1;
                mem_en   = !req_cnt[SEL_W];
                if (memory_data_valid && !rcv_cnt[SEL_W]) begin
                    write_data_array = 1'b1;
                    // Last word: tag goes in alongside the final data write.
                    if (rcv_cnt[SEL_W-1:0] == '1) begin
                        write_tag_array = 1'b1;
                        next_state      = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign word_sel  = write_data_array ? rcv_cnt[SEL_W-1:0] : '0;
    assign data_word = write_data_array ? memory_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_cnt      <= '0;
            rcv_cnt      <= '0;
            base_address <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (miss_detected) begin
                    base_address <= miss_address & ~BLK_MASK;
                    req_cnt      <= '0;
                    rcv_cnt      <= '0;
                end
            end else begin
                if (mem_en)
                    req_cnt <= req_cnt + 1'b1;
                if (write_data_array)
                    rcv_cnt <= rcv_cnt + 1'b1;
            end
        end
    end

`ifdef CACHE_FILL_PERF_EN
    // Counts only completed fills; a reset mid-fill never reaches the tag pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fill_count <= '0;
        else if (write_tag_array && fill_count != 16'hFFFF)
            fill_count <= fill_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy, mem_en, write_data_array, write_tag_array;
    logic [15:0] memory_address, memory_data, data_word, base_address;
    logic        memory_data_valid;
    logic [2:0]  word_sel;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0] fill_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .mem_en(mem_en), .memory_address(memory_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .write_data_array(write_data_array), .word_sel(word_sel),
        .data_word(data_word), .write_tag_array(write_tag_array),
        .base_address(base_address)
`ifdef CACHE_FILL_PERF_EN
        , .fill_count(fill_count)
`endif
    );

    // Memory model: a request in cycle k returns in cycle k+3, so the last of
    // 8 requests lands on busy cycle 11. Contents: mem[a] = a ^ 0xA5A5.
    logic [2:0]  pv;
    logic [15:0] pa [3];
    logic        spur_v;
    logic [15:0] spur_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < 3; i++) pa[i] <= '0;
        end else begin
            pv    <= {pv[1:0], mem_en};
            pa[0] <= memory_address;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
        end
    end

    assign memory_data_valid = pv[2] | spur_v;
    assign memory_data       = pv[2] ? (pa[2] ^ 16'hA5A5) : spur_d;

    // Monitor: logs activity mid-cycle for the test tasks to inspect.
    int          req_n, wr_n, tag_n, busy_n, tag_at;
    logic [15:0] req_a  [32];
    logic [2:0]  wsel   [32];
    logic [15:0] wdat   [32];
    logic [15:0] tag_b  [8];

    always @(negedge clk) begin
        if (mem_en && req_n < 32) begin req_a[req_n] = memory_address; req_n++; end
        if (write_data_array && wr_n < 32) begin
            wsel[wr_n] = word_sel; wdat[wr_n] = data_word; wr_n++;
        end
        if (write_tag_array && tag_n < 8) begin
            tag_b[tag_n] = base_address; tag_n++; tag_at = wr_n;
        end
        if (fsm_busy) busy_n++;
    end

    task automatic clr();
        req_n = 0; wr_n = 0; tag_n = 0; busy_n = 0; tag_at = 0;
    endtask

    task automatic do_miss(input logic [15:0] a);
        @(negedge clk);
        miss_detected = 1'b1; miss_address = a;
        @(negedge clk);
        miss_detected = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && fsm_busy; i++) @(negedge clk);
        checks++;
        if (fsm_busy !== 1'b0) begin
            errors++; $display("FAIL fill_timeout: fsm_busy=%b, required 0", fsm_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        spur_v = 1'b0; spur_d = '0;
        #12;
        checks++;
        if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 0000",
                               {fsm_busy, mem_en, write_data_array, write_tag_array});
        end
        checks++;
        if (base_address !== 16'h0 || memory_address !== 16'h0) begin
            errors++; $display("FAIL reset_addr: base=%h mem=%h, required 0000 0000",
                               base_address, memory_address);
        end
        checks++;
        if (word_sel !== 3'd0 || data_word !== 16'h0) begin
            errors++; $display("FAIL reset_data: sel=%0d data=%h, required 0 0000", word_sel, data_word);
        end
`ifdef CACHE_FILL_PERF_EN
        checks++;
        if (fill_count !== 16'd0) begin
            errors++; $display("FAIL reset_fill_count: got %0d, required 0", fill_count);
        end
`endif
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_fill();
        clr();
        do_miss(16'h1236);
        checks++;
        if (base_address !== 16'h1230) begin
            errors++; $display("FAIL basic_base: got %h, required 1230", base_address);
        end
        wait_done();
        checks++;
        if (req_n !== 8) begin
            errors++; $display("FAIL basic_req_count: got %0d, required 8", req_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (req_a[i] !== 16'h1230 + 16'(2 * i)) begin
                errors++; $display("FAIL basic_req_addr[%0d]: got %h, required %h",
                                   i, req_a[i], 16'h1230 + 16'(2 * i));
            end
        end
        checks++;
        if (wr_n !== 8) begin
            errors++; $display("FAIL basic_wr_count: got %0d, required 8", wr_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wsel[i] !== 3'(i) || wdat[i] !== ((16'h1230 + 16'(2 * i)) ^ 16'hA5A5)) begin
                errors++; $display("FAIL basic_write[%0d]: sel=%0d data=%h, required %0d %h",
                                   i, wsel[i], wdat[i], i, (16'h1230 + 16'(2 * i)) ^ 16'hA5A5);
            end
        end
        checks++;
        if (tag_n !== 1 || tag_at !== 8 || tag_b[0] !== 16'h1230) begin
            errors++; $display("FAIL basic_tag: pulses=%0d at_write=%0d base=%h, required 1 8 1230",
                               tag_n, tag_at, tag_b[0]);
        end
        checks++;
        if (busy_n !== 11) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d, required 11", busy_n);
        end
    endtask

    task automatic test_miss_during_fill();
        clr();
        @(negedge clk);
        miss_detected = 1'b1; miss_address = 16'h4000;
        repeat (6) @(negedge clk);
        miss_address = 16'h8000;
        wait_done();
        // First idle cycle: miss is still asserted and will be taken this edge.
        checks++;
        if (tag_n !== 1 || tag_b[0] !== 16'h4000 || req_a[7] !== 16'h400E) begin
            errors++; $display("FAIL mdf_first_fill: tags=%0d base=%h last_req=%h, required 1 4000 400e",
                               tag_n, tag_b[0], req_a[7]);
        end
        @(negedge clk);
        miss_detected = 1'b0;
        checks++;
        if (fsm_busy !== 1'b1 || base_address !== 16'h8000) begin
            errors++; $display("FAIL mdf_second_start: busy=%b base=%h, required 1 8000",
                               fsm_busy, base_address);
        end
        wait_done();
        checks++;
        if (tag_n !== 2 || tag_b[1] !== 16'h8000 || wr_n !== 16) begin
            errors++; $display("FAIL mdf_second_fill: tags=%0d base=%h writes=%0d, required 2 8000 16",
                               tag_n, tag_b[1], wr_n);
        end
    endtask

    task automatic test_reset_mid_fill();
        clr();
        do_miss(16'h2000);
        for (int i = 0; i < 40 && wr_n < 3; i++) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0 ||
            base_address !== 16'h0 || memory_address !== 16'h0 || word_sel !== 3'd0) begin
            errors++; $display("FAIL rmf_outputs: ctrl=%b base=%h mem=%h sel=%0d, required 0000 0000 0000 0",
                               {fsm_busy, mem_en, write_data_array, write_tag_array},
                               base_address, memory_address, word_sel);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tag_n !== 0 || wr_n !== 3) begin
            errors++; $display("FAIL rmf_aborted: tags=%0d writes=%0d, required 0 3", tag_n, wr_n);
        end
        clr();
        do_miss(16'h3000);
        wait_done();
        checks++;
        if (wr_n !== 8 || wsel[0] !== 3'd0 || wdat[0] !== (16'h3000 ^ 16'hA5A5) || tag_n !== 1) begin
            errors++; $display("FAIL rmf_restart: writes=%0d sel0=%0d data0=%h tags=%0d, required 8 0 %h 1",
                               wr_n, wsel[0], wdat[0], tag_n, 16'h3000 ^ 16'hA5A5);
        end
    endtask

    task automatic test_top_block();
        clr();
        do_miss(16'hFFFF);
        checks++;
        if (base_address !== 16'hFFF0) begin
            errors++; $display("FAIL top_base: got %h, required fff0", base_address);
        end
        wait_done();
        checks++;
        if (req_n !== 8 || req_a[0] !== 16'hFFF0 || req_a[7] !== 16'hFFFE) begin
            errors++; $display("FAIL top_reqs: n=%0d first=%h last=%h, required 8 fff0 fffe",
                               req_n, req_a[0], req_a[7]);
        end
        checks++;
        if (memory_address !== 16'hFFFE || wr_n !== 8 || tag_n !== 1) begin
            errors++; $display("FAIL top_hold: mem=%h writes=%0d tags=%0d, required fffe 8 1",
                               memory_address, wr_n, tag_n);
        end
    endtask

    task automatic test_spurious_valid();
        clr();
        @(negedge clk);
        spur_v = 1'b1; spur_d = 16'hBEEF;
        repeat (3) @(negedge clk);
        spur_v = 1'b0;
        checks++;
        if (wr_n !== 0 || tag_n !== 0) begin
            errors++; $display("FAIL spur_idle: writes=%0d tags=%0d, required 0 0", wr_n, tag_n);
        end
        do_miss(16'h0500);
        wait_done();
        spur_v = 1'b1;
        repeat (2) @(negedge clk);
        spur_v = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_n !== 8 || tag_n !== 1) begin
            errors++; $display("FAIL spur_after_fill: writes=%0d tags=%0d, required 8 1", wr_n, tag_n);
        end
    endtask

`ifdef CACHE_FILL_PERF_EN
    task automatic test_perf_count();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        do_miss(16'h0100); wait_done();
        do_miss(16'h0200); wait_done();
        checks++;
        if (fill_count !== 16'd2) begin
            errors++; $display("FAIL perf_two_fills: got %0d, required 2", fill_count);
        end
        do_miss(16'h0300);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (fill_count !== 16'd0) begin
            errors++; $display("FAIL perf_after_reset: got %0d, required 0", fill_count);
        end
        @(negedge clk); rst = 1'b0;
        do_miss(16'h0400); wait_done();
        checks++;
        if (fill_count !== 16'd1) begin
            errors++; $display("FAIL perf_final: got %0d, required 1", fill_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fill();
        test_miss_during_fill();
        test_reset_mid_fill();
        test_top_block();
        test_spurious_valid();
`ifdef CACHE_FILL_PERF_EN
        test_perf_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
